intr_fix_timer: RTL



---
 rtl/intr_fix_timer.sv | 118 +++++++++++
 1 files changed

// File: rtl/intr_fix_timer.sv
// Periodic fix/interrupt strobe generator for the correlator time scale, with doinit, PPS and cur_time sequencing.
// Optional build macro INTR_PPS_ALIGN_EN: each sec_in re-phases the period counter so the interrupt grid tracks PPS.
module intr_fix_timer #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ICNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [CNT_W-1:0]  intr_period,
   input  logic              period_wr,
   input  logic              doinit_set,
   input  logic              time_req,
   input  logic              pps_in,
   input  logic              intr_clr,
   output logic              fix_pulse,
   output logic              intr_pulse,
   output logic              intr_fix_pulse,
   output logic              doinit,
   output logic              sec_in,
   output logic              cur_time,
   output logic              time_ack,
   output logic              intr_flag,
   output logic [ICNT_W-1:0] intr_count
);

   localparam logic [CNT_W-1:0] MIN_P = CNT_W'(2);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       shadow_q, shadow_d;
   logic [CNT_W-1:0]       term_q, term_d;
   logic                   fix_q, fix_d;
   logic                   intr_q;
   logic                   doinit_q, doinit_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;
   logic                   sec_q, sec_d;
   logic                   cur_q, cur_d;
   logic                   ack_q;
   logic                   flag_q, flag_d;
   logic [ICNT_W-1:0]      icnt_q, icnt_d;

   logic wrap;
   logic reload;

   // The terminal value (P-1) is latched only at a wrap, a PPS reload or while idle,
   // so a period_wr mid-interval never shortens or stretches the running interval.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      shadow_d = period_wr ? intr_period : shadow_q;
      wrap     = enable && (cnt_q == term_q);
`ifdef INTR_PPS_ALIGN_EN
      reload   = enable && sec_q;
`else
      reload   = 1'b0;
`endif
      cnt_d    = cnt_q + ONE;
      if (!enable || reload || wrap) begin
         cnt_d = '0;
      end
      term_d = term_q;
      if (!enable || reload || wrap) begin
         term_d = ((shadow_d < MIN_P) ? MIN_P : shadow_d) - ONE;
      end
      fix_d    = wrap;
      doinit_d = doinit_set || (doinit_q && !intr_q);
      sec_d    = sync_q[SYNC_STAGES-1] && !edge_q;
      cur_d    = time_req && !cur_q && !ack_q;
      flag_d   = intr_q || (flag_q && !intr_clr);
      icnt_d   = intr_q ? icnt_q + ICNT_W'(1) : icnt_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         shadow_q <= '0;
         term_q   <= MIN_P - ONE;
         fix_q    <= 1'b0;
         intr_q   <= 1'b0;
         doinit_q <= 1'b0;
         sync_q   <= '0;
         edge_q   <= 1'b0;
         sec_q    <= 1'b0;
         cur_q    <= 1'b0;
         ack_q    <= 1'b0;
         flag_q   <= 1'b0;
         icnt_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values, which the shift chains rely on.
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         term_q   <= term_d;
         fix_q    <= fix_d;
         intr_q   <= fix_q;
         doinit_q <= doinit_d;
         sync_q   <= {sync_q[SYNC_STAGES-2:0], pps_in};
         edge_q   <= sync_q[SYNC_STAGES-1];
         sec_q    <= sec_d;
         cur_q    <= cur_d;
         ack_q    <= cur_q;
         flag_q   <= flag_d;
         icnt_q   <= icnt_d;
      end
   end

   assign fix_pulse      = fix_q;
   assign intr_pulse     = intr_q;
   assign intr_fix_pulse = intr_q;
   assign doinit         = doinit_q;
   assign sec_in         = sec_q;
   assign cur_time       = cur_q;
   assign time_ack       = ack_q;
   assign intr_flag      = flag_q;
   assign intr_count     = icnt_q;

endmodule
